feature_cache_read_arbiter: RTL and testbench
=============================================

// Module: feature_cache_read_arbiter
// PURPOSE
//  Shares the single read port of the feature cache RAM among NUM_REQ requesters.
//  Arbitration is round-robin, one grant per clock.
//  The RAM registers its read address and has an unregistered output, so data is
//  valid in the cycle after the address is presented.
//  Blocks same-cycle read/write address collisions, because mixed-port
//  read-during-write is undefined. Sits between the feature consumers and the
//  cache; the write port is driven elsewhere and only snooped here.
// PARAMETERS
//  NUM_REQ     4   number of read requesters (>=2)
//  ADDR_WIDTH  10  cache address width
//  WORD_SIZE   8   cache word width
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   asynchronous reset, active-high
//  req_valid    in   NUM_REQ             requester i has a read pending
//  req_addr     in   NUM_REQ*ADDR_WIDTH  read address of requester i, slice i
//  req_ready    out  NUM_REQ             one-hot grant; request i is consumed this cycle
//  rsp_valid    out  NUM_REQ             one-hot; read data for requester i is on rsp_data
//  rsp_data     out  WORD_SIZE           registered read data
//  wr_we        in   1                   snooped cache write enable
//  wr_addr      in   ADDR_WIDTH          snooped cache write address
//  cache_raddr  out  ADDR_WIDTH          to cache read port address
//  cache_q      in   WORD_SIZE           from cache read port data
// BEHAVIOUR
//  - Reset (async, active-high):
//    - rr_ptr=0, s1_valid=0, s1_id=0.
//    - rsp_valid=0, rsp_data=0.
//    - In-flight reads are dropped and never answered.
//  - Eligibility, cycle t: elig[i] = req_valid[i] & ~(wr_we & wr_addr==addr[i]).
//  - Grant, cycle t:
//    - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//    - req_ready is combinational; it is one-hot[winner], or 0 if nothing is eligible.
//    - A collision-masked requester is skipped this cycle; another requester may win.
//  - cache_raddr:
//    - Equals addr[winner] when a grant is made.
//    - Otherwise it holds its last value; no combinational glitch to 0.
//  - Pointer: on a grant, rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
//    Unchanged when there is no grant.
//  - Stage 1 (t+1):
//    - s1_valid and s1_id are registered from the grant.
//    - cache_q is valid in this cycle.
//  - Stage 2 (t+2):
//    - rsp_data <= cache_q when s1_valid; otherwise it holds its value.
//    - rsp_valid <= s1_valid ? onehot(s1_id) : 0.
//  - Latency and throughput:
//    - Grant to rsp_valid is exactly 2 cycles.
//    - Throughput is 1 read per cycle; back-to-back grants are allowed.
//  - Responses carry no backpressure. Requesters must accept rsp in the cycle it is
//    presented.
//  - Requesters must hold req_valid and req_addr stable until req_ready.
//    Deasserting before the grant is allowed, and that request is lost.
//  - A write one cycle before a read to the same address is not a hazard.
//    Only the same cycle is blocked.
//  - A persistent colliding write on one address can stall that requester
//    indefinitely. This is accepted: write bursts are bounded by the producer.
// STRUCTURE
//  - Package pkg_featureCache holds: ADDR_WIDTH, WORD_SIZE, NUM_REQ defaults;
//    typedef req_id_t = logic[$clog2(NUM_REQ)-1:0].
//  - Sub-module rr_arbiter:
//    - Parameter N; inputs req[N], ptr; outputs gnt[N] one-hot, gnt_id, any.
//    - Purely combinational; rr_ptr is owned by the parent.
//  - Parent owns: collision masking, rr_ptr, the 2-stage tag/data pipeline, the
//    raddr hold register.
// TESTING
//  1. Single requester 2, addr=0x05, RAM[5]=0xA7:
//     -> req_ready[2] in cycle t; rsp_valid=4'b0100, rsp_data=0xA7 at t+2.
//  2. All 4 valid continuously, distinct addrs:
//     -> grants 0,1,2,3,0,... one per cycle.
//     -> rsp_valid order matches grants with 2-cycle lag.
//  3. Req0 addr=0x10 and req1 addr=0x20; same cycle wr_we=1, wr_addr=0x10, rr_ptr=0:
//     -> req1 granted, req0 not.
//     -> next cycle (no write) req0 granted and reads the newly written value.
//  4. Only req3 valid, colliding write for 3 cycles:
//     -> req_ready=0 for 3 cycles, grant in the 4th.
//     -> rr_ptr unchanged while stalled.
//  5. rst pulsed 1 cycle after a grant:
//     -> rsp_valid stays 0 (no response for the dropped read).
//     -> after release the first grant goes to req0.
//  6. Random: constrained-random valid/addr/writes against a reference model.
//     -> every granted read gets exactly one response, data equal to the model RAM,
//        2 cycles later.
//     -> no requester starves while it has no colliding writes.

Source files
------------

// File: rtl/feature_cache_read_arbiter_pkg.sv
// Shared defaults and types for the feature cache read arbiter.
// Requester ids are sized from the default requester count.
package pkg_featureCache;

   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 10;
   localparam int WORD_SIZE  = 8;

   typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/feature_cache_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
// The pointer is owned by the parent.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 any
);

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx[$clog2(N)-1:0];
         end
      end
   end

endmodule

// File: rtl/feature_cache_read_arbiter.sv
// Round-robin share of the feature cache read port with same-cycle
// write collision masking and a 2-stage tag/data response pipeline.
module feature_cache_read_arbiter
   import pkg_featureCache::*;
#(
   parameter int NUM_REQ    = pkg_featureCache::NUM_REQ,
   parameter int ADDR_WIDTH = pkg_featureCache::ADDR_WIDTH,
   parameter int WORD_SIZE  = pkg_featureCache::WORD_SIZE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [WORD_SIZE-1:0]          rsp_data,
   input  logic                          wr_we,
   input  logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [ADDR_WIDTH-1:0]         cache_raddr,
   input  logic [WORD_SIZE-1:0]          cache_q
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    gnt;
   logic [IDW-1:0]        gnt_id;
   logic                  any;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  s1_valid_q;
   logic [IDW-1:0]        s1_id_q;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [WORD_SIZE-1:0]  rsp_data_q, rsp_data_d;

   // Mixed-port read-during-write is undefined, so hide colliding reads.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] &
                   ~(wr_we & (wr_addr == req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]));
      end
   end

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr (
      .req    (elig),
      .ptr    (rr_ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      raddr_d  = raddr_q;
      if (any) begin
         rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         raddr_d  = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (s1_valid_q) begin
         rsp_valid_d = NUM_REQ'(1) << s1_id_q;
         rsp_data_d  = cache_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         raddr_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         raddr_q     <= raddr_d;
         s1_valid_q  <= any;
         s1_id_q     <= gnt_id;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready   = gnt;
   assign cache_raddr = raddr_d;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_feature_cache_read_arbiter.sv
// Directed and random checks of the feature cache read arbiter
// against a behavioural cache RAM and arbitration model.
module tb_feature_cache_read_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rv;
   logic [9:0]  ra [4];
   logic [39:0] req_addr;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        we;
   logic [9:0]  wa;
   logic [7:0]  wd;
   logic [9:0]  cache_raddr;
   logic [7:0]  cache_q;

   logic [7:0]  mem [1024];
   logic [9:0]  ram_ra;

   int          n_vec = 0;
   int          n_err = 0;

   int          m_ptr;
   logic        p1_v, p2_v;
   int          p1_id, p2_id;
   logic [9:0]  p1_a, m_raddr;
   logic [7:0]  p2_d, exp_data;
   logic [3:0]  m_elig;
   int          last_w;
   logic        last_any;
   logic [3:0]  s_ready, s_rspv;
   logic [7:0]  s_rspd;

   always #5 clk = ~clk;

   assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

   always @(posedge clk) begin
      if (we) mem[wa] <= wd;
      ram_ra <= cache_raddr;
   end
   assign cache_q = mem[ram_ra];

   feature_cache_read_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (rv),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .wr_we       (we),
      .wr_addr     (wa),
      .cache_raddr (cache_raddr),
      .cache_q     (cache_q)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      logic [3:0] eg;
      logic       anyg;
      int         w;
      @(negedge clk);
      s_ready = req_ready;
      s_rspv  = rsp_valid;
      s_rspd  = rsp_data;
      if (rst) begin
         chk("rst_rspv", 32'(rsp_valid), 0);
         chk("rst_rspd", 32'(rsp_data), 0);
         m_ptr    = 0;
         p1_v     = 1'b0;
         p2_v     = 1'b0;
         exp_data = '0;
         m_raddr  = '0;
         m_elig   = '0;
         last_any = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++)
            eg[i] = rv[i] && !(we && wa == ra[i]);
         anyg = 1'b0;
         w    = 0;
         for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (!anyg && eg[j]) begin
               anyg = 1'b1;
               w    = j;
            end
         end
         chk("gnt", 32'(req_ready), anyg ? 32'(1 << w) : 0);
         if (anyg) m_raddr = ra[w];
         chk("raddr", 32'(cache_raddr), 32'(m_raddr));
         if (p2_v) exp_data = p2_d;
         chk("rspv", 32'(rsp_valid), p2_v ? 32'(1 << p2_id) : 0);
         chk("rspd", 32'(rsp_data), 32'(exp_data));
         p2_v  = p1_v;
         p2_id = p1_id;
         p2_d  = mem[p1_a];
         p1_v  = anyg;
         p1_id = w;
         p1_a  = ra[w];
         if (anyg) m_ptr = (w + 1) % 4;
         m_elig   = eg;
         last_w   = w;
         last_any = anyg;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rv = '0;
      we = 1'b0;
   endtask

   initial begin
      int maxw;
      int wt [4];
      rst = 1'b1;
      rv  = '0;
      we  = 1'b0;
      wa  = '0;
      wd  = '0;
      for (int i = 0; i < 4; i++) ra[i] = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
      mem[5] = 8'hA7;

      step();
      step();
      chk("rst_ready", 32'(s_ready), 0);
      rst = 1'b0;

      // single requester 2
      rv = 4'b0100; ra[2] = 10'h005;
      step();
      chk("t1_gnt", 32'(s_ready), 32'h4);
      idle();
      step();
      step();
      chk("t1_rspv", 32'(s_rspv), 32'h4);
      chk("t1_rspd", 32'(s_rspd), 32'hA7);

      // all four continuously, from a fresh pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) ra[i] = 10'(10'h100 + i);
      rv = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t2_gnt", 32'(s_ready), 32'(1 << (k % 4)));
         if (k >= 2) chk("t2_rspv", 32'(s_rspv), 32'(1 << ((k - 2) % 4)));
      end
      idle();
      step();
      step();

      // collision on req0 address
      ra[0] = 10'h010; ra[1] = 10'h020;
      rv = 4'b0011; we = 1'b1; wa = 10'h010; wd = 8'hC3;
      step();
      chk("t3_gnt1", 32'(s_ready), 32'h2);
      we = 1'b0; rv = 4'b0001;
      step();
      chk("t3_gnt0", 32'(s_ready), 32'h1);
      idle();
      step();
      chk("t3_rspv1", 32'(s_rspv), 32'h2);
      chk("t3_rspd1", 32'(s_rspd), 32'hAB);
      step();
      chk("t3_rspv0", 32'(s_rspv), 32'h1);
      chk("t3_rspd0", 32'(s_rspd), 32'hC3);

      // req3 stalled by a 3-cycle colliding write
      rv = 4'b1000; ra[3] = 10'h033;
      we = 1'b1; wa = 10'h033; wd = 8'h3C;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_stall", 32'(s_ready), 0);
      end
      chk("t4_ptr", 32'(dut.rr_ptr_q), 1);
      we = 1'b0;
      step();
      chk("t4_gnt", 32'(s_ready), 32'h8);
      idle();
      step();
      step();
      chk("t4_rspv", 32'(s_rspv), 32'h8);
      chk("t4_rspd", 32'(s_rspd), 32'h3C);

      // reset one cycle after a grant drops the read
      rv = 4'b0001; ra[0] = 10'h040;
      step();
      chk("t5_gnt", 32'(s_ready), 32'h1);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("t5_rspv_a", 32'(s_rspv), 0);
      step();
      chk("t5_rspv_b", 32'(s_rspv), 0);
      rv = 4'b1111;
      step();
      chk("t5_first", 32'(s_ready), 32'h1);
      idle();
      step();
      step();

      // random traffic, requests held until granted
      maxw = 0;
      for (int i = 0; i < 4; i++) wt[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!rv[i] || (last_any && last_w == i)) begin
               rv[i] = 1'($urandom % 2);
               ra[i] = 10'($urandom_range(0, 15));
            end
         end
         we = ($urandom % 4) == 0;
         wa = 10'($urandom_range(0, 15));
         wd = 8'($urandom);
         step();
         for (int i = 0; i < 4; i++) begin
            if (m_elig[i] && !(last_any && last_w == i)) wt[i]++;
            else wt[i] = 0;
            if (wt[i] > maxw) maxw = wt[i];
         end
      end
      chk("starve", 32'(maxw <= 3), 1);
      idle();
      step();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
